xc_malu_div: RTL and testbench
==============================

# xc_malu_div

Iterative restoring shift-subtract divider for the XCrypto multi-cycle ALU. It implements RISC-V `div`, `divu`, `rem` and `remu`, and is the inverse datapath to the shift-add multiplier. One quotient bit is produced per cycle over 32 iteration cycles, behind a valid/ready handshake from the MALU issue logic.

## Interface
- No parameters; step count fixed at 32.
- `g_clk` in 1: clock, rising edge.
- `g_reset` in 1: asynchronous, active-high reset.
- `valid` in 1: request; held high with operands stable until `ready`.
- `flush` in 1: synchronous abort of any in-flight operation.
- `op_div` in 1: signed quotient.
- `op_divu` in 1: unsigned quotient.
- `op_rem` in 1: signed remainder.
- `op_remu` in 1: unsigned remainder.
- Exactly one `op_*` is high while `valid` is high.
- `rs1` in 32: dividend.
- `rs2` in 32: divisor.
- `ready` out 1: single-cycle pulse; `result` valid in that cycle.
- `result` out 32: quotient or remainder.
- `busy` out 1: high in CALC and DONE.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE. Reset values: `ready`=0, `busy`=0, `result`=0, counter=0, all datapath registers 0.
- IDLE, `valid` and not `flush`:
  - Latch |rs1| into the quotient register and |rs2| into the divisor register. Magnitude is taken only for signed ops.
  - Clear the 32-bit remainder register and the counter.
  - Latch the op and the signs: `neg_q` = rs1[31]^rs2[31], `neg_r` = rs1[31], both signed ops only. Latch `dz` = (rs2==0).
  - Go to CALC.
- CALC step, 33-bit arithmetic:
  - t = {rem, quot[31]} − {1'b0, div}.
  - If t[32]==0: rem←t[31:0] and quotient bit 1.
  - Otherwise: rem←{rem[30:0], quot[31]} and quotient bit 0.
  - quot←{quot[30:0], qbit}. counter++.
  - When counter==31 the step executes and the state goes to DONE.
- DONE:
  - `ready`=1.
  - Quotient ops: `result` = (neg_q && !dz) ? −quot : quot.
  - Remainder ops: `result` = neg_r ? −rem : rem.
  - Next state IDLE.
- Divide by zero needs no special path. The unsigned loop yields quot=0xFFFFFFFF and rem=|rs1|. Quotient negation is suppressed by `dz`, so div/divu return 0xFFFFFFFF and rem/remu return rs1.
- Overflow (−2^31 / −1): |rs1|=0x80000000, quot=0x80000000, neg_q=0 → div=0x80000000, rem=0, matching the ISA with no special path.
- `flush` takes priority in every state: next state IDLE, counter cleared. `ready` is not asserted in that cycle or the next.
- `valid` sampled high in IDLE in the cycle immediately after `ready` starts a new operation. The requester drops `valid` or presents the next op.
- `valid` is ignored in CALC and DONE. Operand changes during CALC have no effect.
- Reset asserted mid-operation: immediate return to IDLE with the reset values above.

## Timing
- `valid` sampled in cycle n (IDLE) → CALC in cycles n+1..n+32 → DONE and `ready` in cycle n+33. Fixed 34-cycle occupancy, independent of operands.
- `result` is registered-state driven, not combinationally from `rs1`/`rs2`. The output negation is combinational from internal registers.
- `ready` is never high for two consecutive cycles.
- Back-to-back throughput is one operation per 34 cycles.

## Structure
- Shared package `xc_malu_pkg`: `XC_DIV_STEPS`=32, state encodings `XC_DIV_IDLE`/`XC_DIV_CALC`/`XC_DIV_DONE`, and a 5-bit counter width constant.
- One combinational sub-module, `xc_malu_div_step`.
  - Inputs: rem, quot, div.
  - Outputs: next rem, next quot.
  - Holds the 33-bit trial subtract so it can be checked in isolation against a golden model.
- The top holds the FSM, counter, operand conditioning and sign fix-up.

## Test plan
- divu rs1=100, rs2=7 → `ready` exactly 33 cycles after the `valid` cycle, `result`=14. Repeat as remu → 2.
- div rs1=0xFFFFFF9C (−100), rs2=7 → 0xFFFFFFF2 (−14). rem of the same operands → 0xFFFFFFFE (−2).
- div rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000. rem of the same operands → 0.
- div and divu rs1=0xFFFFFF9C, rs2=0 → 0xFFFFFFFF. rem and remu → 0xFFFFFF9C.
- `flush` at CALC cycle 10, then a new divu 9/3 → no `ready` for the aborted op; result=3 with full 34-cycle latency.
- `g_reset` pulsed mid-CALC → outputs return to 0 asynchronously, state IDLE. Random signed/unsigned regression against a reference model thereafter.

Source files
------------

// File: rtl/xc_malu_pkg.sv
// rtl/xc_malu_pkg.sv - shared constants and state encodings for the MALU divider
package xc_malu_pkg;

  localparam int XC_DIV_STEPS = 32;
  localparam int XC_DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    XC_DIV_IDLE = 2'd0,
    XC_DIV_CALC = 2'd1,
    XC_DIV_DONE = 2'd2
  } xc_div_state_e;

endpackage

// File: rtl/xc_malu_div_step.sv
// rtl/xc_malu_div_step.sv - one restoring shift-subtract step, one quotient bit per call
module xc_malu_div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quot,
  input  logic [31:0] div,
  output logic [31:0] rem_next,
  output logic [31:0] quot_next
);

  logic [32:0] trial;
  logic        qbit;

  always_comb begin
    // 33-bit trial keeps the borrow visible even when rem has its top bit set
    trial     = {rem, quot[31]} - {1'b0, div};
    qbit      = ~trial[32];
    rem_next  = qbit ? trial[31:0] : {rem[30:0], quot[31]};
    quot_next = {quot[30:0], qbit};
  end

endmodule

// File: rtl/xc_malu_div.sv
// rtl/xc_malu_div.sv - iterative 32-step divider for div/divu/rem/remu
module xc_malu_div
  import xc_malu_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        valid,
  input  logic        flush,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic        op_rem,
  input  logic        op_remu,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        ready,
  output logic [31:0] result,
  output logic        busy
);

  xc_div_state_e             state_q, state_d;
  logic [XC_DIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]               rem_q, rem_d;
  logic [31:0]               quot_q, quot_d;
  logic [31:0]               div_q, div_d;
  logic                      neg_q_q, neg_q_d;
  logic                      neg_r_q, neg_r_d;
  logic                      dz_q, dz_d;
  logic                      is_rem_q, is_rem_d;
  logic                      ready_q, ready_d;

  logic [31:0] step_rem;
  logic [31:0] step_quot;
  logic        signed_op;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  xc_malu_div_step u_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .div       (div_q),
    .rem_next  (step_rem),
    .quot_next (step_quot)
  );

  assign signed_op = op_div | op_rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    div_d    = div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    is_rem_d = is_rem_q;
    ready_d  = 1'b0;

    if (flush) begin
      state_d = XC_DIV_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        XC_DIV_IDLE: begin
          if (valid) begin
            quot_d   = (signed_op && rs1[31]) ? -rs1 : rs1;
            div_d    = (signed_op && rs2[31]) ? -rs2 : rs2;
            rem_d    = '0;
            cnt_d    = '0;
            neg_q_d  = signed_op & (rs1[31] ^ rs2[31]);
            neg_r_d  = signed_op & rs1[31];
            dz_d     = (rs2 == 32'd0);
            is_rem_d = op_rem | op_remu;
            state_d  = XC_DIV_CALC;
          end
        end
        XC_DIV_CALC: begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + XC_DIV_CNT_W'(1);
          if (cnt_q == XC_DIV_CNT_W'(XC_DIV_STEPS - 1)) begin
            state_d = XC_DIV_DONE;
            ready_d = 1'b1;
          end
        end
        XC_DIV_DONE: begin
          state_d = XC_DIV_IDLE;
        end
        default: begin
          state_d = XC_DIV_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q  <= XC_DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      div_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      is_rem_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      div_q    <= div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      is_rem_q <= is_rem_d;
      ready_q  <= ready_d;
    end
  end

  // Divide-by-zero leaves quot all ones; dz stops the sign fix-up from turning that into 1
  assign quot_fix = (neg_q_q && !dz_q) ? -quot_q : quot_q;
  assign rem_fix  = neg_r_q ? -rem_q : rem_q;

  assign ready  = ready_q & ~flush;
  assign result = ready_q ? (is_rem_q ? rem_fix : quot_fix) : 32'd0;
  assign busy   = (state_q != XC_DIV_IDLE);

endmodule

// File: tb/tb_xc_malu_div.sv
// tb/tb_xc_malu_div.sv - scoreboard bench for the iterative divider
module tb_xc_malu_div;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic        op_div = 1'b0;
  logic        op_divu = 1'b0;
  logic        op_rem = 1'b0;
  logic        op_remu = 1'b0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        ready;
  logic [31:0] result;
  logic        busy;

  localparam int OP_DIV = 0, OP_DIVU = 1, OP_REM = 2, OP_REMU = 3;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          due_q[$];
  logic        prev_ready = 1'b0;

  xc_malu_div dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .valid   (valid),
    .flush   (flush),
    .op_div  (op_div),
    .op_divu (op_divu),
    .op_rem  (op_rem),
    .op_remu (op_remu),
    .rs1     (rs1),
    .rs2     (rs2),
    .ready   (ready),
    .result  (result),
    .busy    (busy)
  );

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  function automatic logic [31:0] ref_model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIVU: ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: ref_model = (b == 0) ? a : a % b;
      OP_DIV:  ref_model = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      default: ref_model = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
    endcase
  endfunction

  // Monitor: pops one expectation per ready pulse and checks value and arrival cycle
  always @(negedge g_clk) begin
    if (!g_reset) begin
      if (ready) begin
        if (prev_ready) chk(1'b0, "ready_two_cycles", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_ready", result, 32'd0);
        end else begin
          logic [31:0] e;
          int          d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk(result == e, "result", result, e);
          chk(cyc == d, "ready_latency_cycle", 32'(cyc), 32'(d));
        end
      end
      prev_ready = ready;
    end else begin
      prev_ready = 1'b0;
    end
  end

  task automatic set_op(input int op);
    op_div  = (op == OP_DIV);
    op_divu = (op == OP_DIVU);
    op_rem  = (op == OP_REM);
    op_remu = (op == OP_REMU);
  endtask

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int n;
    @(negedge g_clk);
    set_op(op);
    rs1   = a;
    rs2   = b;
    valid = 1'b1;
    exp_q.push_back(e);
    due_q.push_back(cyc + 33);
    n = 0;
    do begin
      @(negedge g_clk);
      n++;
    end while (!ready && n < 60);
    if (!ready) chk(1'b0, "ready_timeout", 32'(n), 32'd33);
    valid = 1'b0;
  endtask

  task automatic start_only(input int op, input logic [31:0] a, input logic [31:0] b);
    @(negedge g_clk);
    set_op(op);
    rs1   = a;
    rs2   = b;
    valid = 1'b1;
    @(negedge g_clk);
    valid = 1'b0;
    rs1   = 32'hDEAD_BEEF;
    rs2   = 32'h0000_0001;
  endtask

  initial begin
    repeat (3) @(negedge g_clk);
    chk(ready == 1'b0, "reset_ready", 32'(ready), 32'd0);
    chk(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);
    chk(result == 32'd0, "reset_result", result, 32'd0);
    g_reset = 1'b0;
    @(negedge g_clk);
    chk(busy == 1'b0, "idle_busy", 32'(busy), 32'd0);

    issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
    issue(OP_REMU, 32'd100, 32'd7, 32'd2);
    issue(OP_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    issue(OP_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    issue(OP_DIV,  32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF);
    issue(OP_REM,  32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C);
    issue(OP_REMU, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C);
    issue(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    issue(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1);

    // Abort at CALC cycle 10; a ready for it would surface as unexpected_ready
    start_only(OP_DIVU, 32'd50, 32'd5);
    chk(busy == 1'b1, "calc_busy", 32'(busy), 32'd1);
    repeat (9) @(negedge g_clk);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    chk(busy == 1'b0, "flush_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge g_clk);
    issue(OP_DIVU, 32'd9, 32'd3, 32'd3);

    // Asynchronous reset in the middle of CALC
    start_only(OP_DIV, 32'hFFFF_F000, 32'd3);
    repeat (10) @(negedge g_clk);
    #2 g_reset = 1'b1;
    #1;
    chk(busy == 1'b0, "async_reset_busy", 32'(busy), 32'd0);
    chk(ready == 1'b0, "async_reset_ready", 32'(ready), 32'd0);
    chk(result == 32'd0, "async_reset_result", result, 32'd0);
    @(negedge g_clk);
    g_reset = 1'b0;
    repeat (40) @(negedge g_clk);

    for (int i = 0; i < 16; i++) begin
      int          op;
      logic [31:0] a, b;
      op = int'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if (i % 4 == 1) b = b >> 20;
      if (i % 4 == 2) b = -32'($urandom_range(1, 9));
      issue(op, a, b, ref_model(op, a, b));
    end

    repeat (3) @(negedge g_clk);
    chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
